// File: rtl/z2_master_pkg.sv
// Shared types and constants for the Zorro II bus master.
package z2_master_pkg;

  localparam int unsigned ADDR_W             = 23;
  localparam int unsigned DATA_W             = 16;
  localparam int unsigned SYNC_W             = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    OWN,
    ADDR,
    STROBE,
    WAIT,
    TERM,
    RELEASE
  } z2_state_e;

  // Request fields captured at acceptance
  typedef struct packed {
    logic              we;
    logic              hold;
    logic [ADDR_W:1]   addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
  } z2_req_t;

endpackage

// File: rtl/z2_bus_master_if.sv
// Local request port plus Zorro II bus pins of the bus master.
interface z2_bus_master_if;
  import z2_master_pkg::*;

  logic              req;
  logic              req_we;
  logic              req_hold;
  logic [ADDR_W:1]   req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_be;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;

  logic [ADDR_W:1]   ADDR_OUT;
  logic [DATA_W-1:0] DBUS_OUT;
  logic [DATA_W-1:0] DBUS_IN;
  logic              ADDR_OE;
  logic              DBUS_OE;
  logic              CTRL_OE;
  logic              AS_n_OUT;
  logic              UDS_n_OUT;
  logic              LDS_n_OUT;
  logic              RW_OUT;
  logic              DTACK_n;
  logic              BERR_n;
  logic              BG_n;
  logic              AS_n_IN;
  logic              BR_n;
  logic              BGACK_OE;

  modport master (
    input  req, req_we, req_hold, req_addr, req_wdata, req_be,
    output ack, err, rdata,
    output ADDR_OUT, DBUS_OUT, ADDR_OE, DBUS_OE, CTRL_OE,
    output AS_n_OUT, UDS_n_OUT, LDS_n_OUT, RW_OUT, BR_n, BGACK_OE,
    input  DBUS_IN, DTACK_n, BERR_n, BG_n, AS_n_IN
  );

  modport slave (
    output req, req_we, req_hold, req_addr, req_wdata, req_be,
    input  ack, err, rdata,
    input  ADDR_OUT, DBUS_OUT, ADDR_OE, DBUS_OE, CTRL_OE,
    input  AS_n_OUT, UDS_n_OUT, LDS_n_OUT, RW_OUT, BR_n, BGACK_OE,
    output DBUS_IN, DTACK_n, BERR_n, BG_n, AS_n_IN
  );

endinterface

// File: rtl/z2_sync.sv
// Two-flop synchronizer for asynchronous bus inputs.
module z2_sync #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/z2_bus_master.sv
// Zorro II bus master: arbitrates for the bus and runs one 16-bit transfer per request.
// Define Z2_MASTER_TIMEOUT_EN to add a WAIT-state timeout that terminates with err.
module z2_bus_master
  import z2_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            MEMCLK,
  input  logic            RESET,
  z2_bus_master_if.master bus
);

  logic [SYNC_W-1:0] w_sync;
  logic              w_dtack_n;
  logic              w_berr_n;
  logic              w_bg_n;
  logic              w_as_n;
  z2_req_t           w_req_in;
  logic              w_term;
  logic              w_term_err;

  z2_state_e         r_state;
  z2_req_t           r_req;
  logic              r_pend;
  logic              r_br_n;
  logic              r_bgack_oe;
  logic              r_addr_oe;
  logic              r_dbus_oe;
  logic              r_ctrl_oe;
  logic              r_as_n;
  logic              r_uds_n;
  logic              r_lds_n;
  logic              r_rw;
  logic [ADDR_W:1]   r_addr_out;
  logic [DATA_W-1:0] r_dbus_out;
  logic              r_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  z2_sync #(
    .WIDTH   (SYNC_W),
    .RST_VAL ({SYNC_W{1'b1}})
  ) u_sync (
    .i_clk (MEMCLK),
    .i_rst (RESET),
    .i_d   ({bus.DTACK_n, bus.BERR_n, bus.BG_n, bus.AS_n_IN}),
    .o_q   (w_sync)
  );

  assign w_dtack_n = w_sync[3];
  assign w_berr_n  = w_sync[2];
  assign w_bg_n    = w_sync[1];
  assign w_as_n    = w_sync[0];
  assign w_req_in  = {bus.req_we, bus.req_hold, bus.req_addr, bus.req_wdata, bus.req_be};

`ifdef Z2_MASTER_TIMEOUT_EN
  logic [7:0] r_wcnt;
`else
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

  // WAIT termination; BERR has priority over DTACK
  always_comb begin
    w_term     = 1'b0;
    w_term_err = 1'b0;
    if (r_state == WAIT) begin
      if (!w_berr_n) begin
        w_term     = 1'b1;
        w_term_err = 1'b1;
      end else if (!w_dtack_n) begin
        w_term     = 1'b1;
`ifdef Z2_MASTER_TIMEOUT_EN
      end else if (r_wcnt == 8'(TIMEOUT_CYCLES - 1)) begin
        w_term     = 1'b1;
        w_term_err = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge MEMCLK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_req      <= '0;
      r_pend     <= 1'b0;
      r_br_n     <= 1'b1;
      r_bgack_oe <= 1'b0;
      r_addr_oe  <= 1'b0;
      r_dbus_oe  <= 1'b0;
      r_ctrl_oe  <= 1'b0;
      r_as_n     <= 1'b1;
      r_uds_n    <= 1'b1;
      r_lds_n    <= 1'b1;
      r_rw       <= 1'b1;
      r_addr_out <= '0;
      r_dbus_out <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
`ifdef Z2_MASTER_TIMEOUT_EN
      r_wcnt     <= '0;
`endif
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_req <= w_req_in;
            if (bus.req_be == 2'b00) begin
              r_ack <= 1'b1;
              r_err <= 1'b1;
            end else begin
              r_pend  <= 1'b1;
              r_br_n  <= 1'b0;
              r_state <= ARB;
            end
          end
        end
        ARB: begin
          if (!w_bg_n && w_as_n && w_dtack_n) begin
            r_bgack_oe <= 1'b1;
            r_br_n     <= 1'b1;
            r_state    <= OWN;
          end
        end
        // Bus owned: start a pending transfer, pick up a new one, or let go
        OWN: begin
          if (r_pend) begin
            r_pend <= 1'b0;
            if (r_req.be == 2'b00) begin
              r_ack <= 1'b1;
              r_err <= 1'b1;
              if (!r_req.hold) r_state <= RELEASE;
            end else begin
              r_addr_oe  <= 1'b1;
              r_ctrl_oe  <= 1'b1;
              r_addr_out <= r_req.addr;
              r_rw       <= ~r_req.we;
              r_as_n     <= 1'b1;
              r_uds_n    <= 1'b1;
              r_lds_n    <= 1'b1;
              r_dbus_oe  <= r_req.we;
              r_dbus_out <= r_req.wdata;
              r_state    <= ADDR;
            end
          end else if (bus.req) begin
            r_req  <= w_req_in;
            r_pend <= 1'b1;
          end else begin
            r_state <= RELEASE;
          end
        end
        ADDR: begin
          r_as_n <= 1'b0;
          if (!r_req.we) {r_uds_n, r_lds_n} <= ~r_req.be;
          r_state <= STROBE;
        end
        STROBE: begin
          if (r_req.we) {r_uds_n, r_lds_n} <= ~r_req.be;
`ifdef Z2_MASTER_TIMEOUT_EN
          r_wcnt <= '0;
`endif
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_term) begin
            r_as_n    <= 1'b1;
            r_uds_n   <= 1'b1;
            r_lds_n   <= 1'b1;
            r_dbus_oe <= 1'b0;
            r_ack     <= 1'b1;
            r_err     <= w_term_err;
            if (!w_term_err && !r_req.we) r_rdata <= bus.DBUS_IN;
            r_state   <= TERM;
          end
`ifdef Z2_MASTER_TIMEOUT_EN
          else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
`endif
        end
        TERM: begin
          if (w_dtack_n && w_berr_n) r_state <= r_req.hold ? OWN : RELEASE;
        end
        RELEASE: begin
          r_addr_oe  <= 1'b0;
          r_ctrl_oe  <= 1'b0;
          r_bgack_oe <= 1'b0;
          r_dbus_oe  <= 1'b0;
          r_as_n     <= 1'b1;
          r_uds_n    <= 1'b1;
          r_lds_n    <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack       = r_ack;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.ADDR_OUT  = r_addr_out;
  assign bus.DBUS_OUT  = r_dbus_out;
  assign bus.ADDR_OE   = r_addr_oe;
  assign bus.DBUS_OE   = r_dbus_oe;
  assign bus.CTRL_OE   = r_ctrl_oe;
  assign bus.AS_n_OUT  = r_as_n;
  assign bus.UDS_n_OUT = r_uds_n;
  assign bus.LDS_n_OUT = r_lds_n;
  assign bus.RW_OUT    = r_rw;
  assign bus.BR_n      = r_br_n;
  assign bus.BGACK_OE  = r_bgack_oe;

endmodule
